// File: rtl/ram8_ctrl_if.sv
// Host/RAM-facing bundle for ram8_ctrl: command channel, RAM port and read-return stream.
// master = host + RAM side, slave = controller side.
interface ram8_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int LEN_W  = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_op;
  logic [ADDR_W-1:0] cmd_base;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] cmd_data;

  logic              mem_load;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_val;
  logic [DATA_W-1:0] mem_out;

  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;

  modport master (
    output cmd_valid, cmd_op, cmd_base, cmd_len, cmd_data, mem_out, rd_ready,
    input  cmd_ready, mem_load, mem_addr, mem_val, rd_valid, rd_data, rd_last
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_base, cmd_len, cmd_data, mem_out, rd_ready,
    output cmd_ready, mem_load, mem_addr, mem_val, rd_valid, rd_data, rd_last
  );
endinterface

// File: rtl/ram8_ctrl.sv
// FILL/READ block sequencer for the 8x16 registered-output RAM; reads return 1 word per 3 cycles.
// Optional RAM8_CTRL_FILL_INC_EN: FILL writes cmd_data + k instead of a constant value.
module ram8_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int LEN_W  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  ram8_ctrl_if.slave   bus,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WR         = 3'd1,
    RD_ISSUE   = 3'd2,
    RD_CAPTURE = 3'd3,
    RD_HOLD    = 3'd4,
    DONE       = 3'd5
  } state_t;

`ifdef RAM8_CTRL_FILL_INC_EN
  localparam logic [DATA_W-1:0] FILL_STEP = DATA_W'(1);
`else
  localparam logic [DATA_W-1:0] FILL_STEP = '0;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              mem_load_q, mem_load_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_val_q, mem_val_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_last_q, rd_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    mem_load_d = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_val_d  = mem_val_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    rd_last_d  = rd_last_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          ptr_d = bus.cmd_base;
          cnt_d = bus.cmd_len;
          if (bus.cmd_len == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (bus.cmd_op) begin
            state_d    = RD_ISSUE;
            mem_addr_d = bus.cmd_base;
          end else begin
            state_d    = WR;
            mem_load_d = 1'b1;
            mem_addr_d = bus.cmd_base;
            mem_val_d  = bus.cmd_data;
          end
        end
      end
      WR: begin
        if (cnt_q == LEN_W'(1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          ptr_d      = ptr_q + ADDR_W'(1);
          cnt_d      = cnt_q - LEN_W'(1);
          mem_load_d = 1'b1;
          mem_addr_d = ptr_q + ADDR_W'(1);
          mem_val_d  = mem_val_q + FILL_STEP;
        end
      end
      RD_ISSUE: state_d = RD_CAPTURE;
      // RAM output reflects the address issued one edge earlier
      RD_CAPTURE: begin
        rd_data_d  = bus.mem_out;
        rd_valid_d = 1'b1;
        rd_last_d  = (cnt_q == LEN_W'(1));
        state_d    = RD_HOLD;
      end
      RD_HOLD: begin
        if (bus.rd_ready) begin
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
          if (rd_last_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            ptr_d      = ptr_q + ADDR_W'(1);
            cnt_d      = cnt_q - LEN_W'(1);
            mem_addr_d = ptr_q + ADDR_W'(1);
            state_d    = RD_ISSUE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d != IDLE);
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b1;
      mem_load_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_val_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_last_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      mem_load_q  <= mem_load_d;
      mem_addr_q  <= mem_addr_d;
      mem_val_q   <= mem_val_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      rd_last_q   <= rd_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.mem_load  = mem_load_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_val   = mem_val_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_last   = rd_last_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_ram8_ctrl.sv
// Directed bench for ram8_ctrl with a behavioural 8x16 registered-output RAM and a shadow copy of its contents.
module tb_ram8_ctrl;

  logic clk;
  logic rst_n;
  logic busy;
  logic done;

  ram8_ctrl_if bus ();

  ram8_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] ram [8];
  logic [15:0] shadow [8];

  always_ff @(posedge clk) begin
    if (bus.mem_load) ram[bus.mem_addr] <= bus.mem_val;
    bus.mem_out <= ram[bus.mem_addr];
  end

  int n_chk  = 0;
  int n_fail = 0;
  int n_done = 0;
  int exp_done = 0;
  int n_bad_load = 0;
  logic in_read = 1'b0;

  always @(negedge clk) begin
    if (done) n_done++;
    if (in_read && bus.mem_load) n_bad_load++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_done"},      done, 0);
    check({tag, "_mem_load"},  bus.mem_load, 0);
    check({tag, "_mem_addr"},  bus.mem_addr, 0);
    check({tag, "_mem_val"},   bus.mem_val, 0);
    check({tag, "_rd_valid"},  bus.rd_valid, 0);
    check({tag, "_rd_data"},   bus.rd_data, 0);
    check({tag, "_rd_last"},   bus.rd_last, 0);
  endtask

  // Called at a negedge; returns just after the accepting posedge.
  task automatic send_cmd(input logic op, input logic [2:0] base, input logic [3:0] len,
                          input logic [15:0] data);
    check("cmd_ready_idle", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_base  = base;
    bus.cmd_len   = len;
    bus.cmd_data  = data;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 16'hDEAD;
    exp_done++;
  endtask

  task automatic finish_cmd(input string tag);
    @(negedge clk);
    check({tag, "_done_hi"}, done, 1);
    check({tag, "_load_lo"}, bus.mem_load, 0);
    check({tag, "_rdv_lo"},  bus.rd_valid, 0);
    @(negedge clk);
    check({tag, "_done_lo"}, done, 0);
    check({tag, "_busy_lo"}, busy, 0);
  endtask

  // abort_after > 0: assert reset once that many writes have landed in the RAM.
  task automatic run_fill(input logic [2:0] base, input logic [3:0] len, input logic [15:0] data,
                          input int abort_after);
    logic [2:0]  a;
    logic [15:0] v;
    send_cmd(1'b0, base, len, data);
    for (int k = 0; k < int'(len); k++) begin
      a = base + k[2:0];
`ifdef RAM8_CTRL_FILL_INC_EN
      v = data + k[15:0];
`else
      v = data;
`endif
      @(negedge clk);
      check("wr_load", bus.mem_load, 1);
      check("wr_addr", bus.mem_addr, a);
      check("wr_val",  bus.mem_val, v);
      shadow[a] = v;
      if (k + 1 == abort_after) begin
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("abort");
        exp_done--;
        repeat (2) begin
          @(negedge clk);
          check("abort_no_done", done, 0);
        end
        rst_n = 1'b1;
        return;
      end
    end
    finish_cmd("fill");
  endtask

  task automatic run_read(input logic [2:0] base, input logic [3:0] len,
                          input int stall_w, input int stall_n);
    logic [2:0] a;
    int k;
    in_read = 1'b1;
    send_cmd(1'b1, base, len, 16'h0000);
    for (int w = 0; w < int'(len); w++) begin
      a = base + w[2:0];
      k = 0;
      @(negedge clk);
      check("rd_issue_addr", bus.mem_addr, a);
      while (!bus.rd_valid && k < 8) begin
        @(negedge clk);
        k++;
      end
      check("rd_gap", k, 2);
      check("rd_data", bus.rd_data, shadow[a]);
      check("rd_last", bus.rd_last, (w == int'(len) - 1));
      if (w == stall_w) begin
        bus.rd_ready = 1'b0;
        repeat (stall_n) begin
          @(negedge clk);
          check("stall_valid", bus.rd_valid, 1);
          check("stall_data",  bus.rd_data, shadow[a]);
          check("stall_last",  bus.rd_last, (w == int'(len) - 1));
          check("stall_addr",  bus.mem_addr, a);
        end
        bus.rd_ready = 1'b1;
      end
    end
    finish_cmd("read");
    in_read = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 1'b0;
    bus.cmd_base  = '0;
    bus.cmd_len   = '0;
    bus.cmd_data  = '0;
    bus.rd_ready  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ram[i]    = 16'h0000;
      shadow[i] = 16'h0000;
    end

    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("post_rst");

    run_fill(3'd0, 4'd8, 16'hA5A5, 0);
    run_read(3'd0, 4'd8, -1, 0);

    run_fill(3'd6, 4'd4, 16'h1234, 0);
    run_read(3'd6, 4'd4, -1, 0);

    run_read(3'd0, 4'd8, 2, 5);

    run_fill(3'd2, 4'd0, 16'hFFFF, 0);
    run_read(3'd5, 4'd0, -1, 0);

    run_fill(3'd0, 4'd8, 16'h5555, 3);
    @(negedge clk);
    run_read(3'd0, 4'd8, -1, 0);

    run_fill(3'd3, 4'd9, 16'h0F00, 0);
    run_read(3'd5, 4'd10, 9, 2);

    check("done_count", n_done, exp_done);
    check("no_load_in_read", n_bad_load, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
